// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote, parity/framing/overrun flags, valid/ready output.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_os #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_LO     = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0]   S_HI     = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_RX_BREAK_DETECT_EN
    S_BREAK,
`endif
    S_STOP
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_sync1, r_sync2, r_rx_d;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [S_W-1:0]       r_s;
  logic [B_W-1:0]       r_bitcnt;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_mis, r_done, r_ferr_new;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_perr, r_ovr;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 r_brk_new, r_brk;
  logic                 w_brk_frame;
`endif

  logic w_rx, w_start, w_tick, w_dec, w_end, w_maj, w_exp_par, w_hs, w_load;

  assign w_rx      = r_sync2;
  assign w_start   = (r_state == S_IDLE) && enable && r_rx_d && !w_rx;
  assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
  assign w_dec     = w_tick && (r_s == S_HI);
  assign w_end     = w_tick && (r_s == S_LAST);
  assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx) | (r_smp[1] & w_rx);
  assign w_exp_par = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  assign w_hs      = r_valid && ready;
  assign w_load    = r_done && (!r_valid || w_hs);
`ifdef UART_RX_BREAK_DETECT_EN
  assign w_brk_frame = !w_maj && (r_shift == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
      r_state <= S_IDLE;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_START;
      S_START: begin
        if (w_dec && w_maj) w_state_nxt = S_IDLE;
        else if (w_end)     w_state_nxt = S_DATA;
      end
      S_DATA:   if (w_end && (r_bitcnt == B_LAST)) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_end) w_state_nxt = S_STOP;
      S_STOP: begin
`ifdef UART_RX_BREAK_DETECT_EN
        if (w_dec) w_state_nxt = w_brk_frame ? S_BREAK : S_IDLE;
`else
        if (w_dec) w_state_nxt = S_IDLE;
`endif
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BREAK:  if (w_tick && w_rx && (r_s == S_LAST)) w_state_nxt = S_IDLE;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_s       <= '0;
      r_bitcnt  <= '0;
    end else if (w_start) begin
      r_div_cnt <= '0;
      r_s       <= '0;
      r_bitcnt  <= '0;
    end else if (r_state != S_IDLE) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
`ifdef UART_RX_BREAK_DETECT_EN
        // In BREAK, r_s counts consecutive high samples instead of bit phase.
        if (r_state == S_STOP && w_state_nxt == S_BREAK) r_s <= '0;
        else if (r_state == S_BREAK) r_s <= w_rx ? r_s + 1'b1 : '0;
        else
`endif
        r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
      end
      if (r_state == S_DATA && w_end) r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp      <= '1;
      r_shift    <= '0;
      r_par_mis  <= 1'b0;
      r_done     <= 1'b0;
      r_ferr_new <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_brk_new  <= 1'b0;
`endif
    end else begin
      if (w_tick && r_s == S_LO)  r_smp[0] <= w_rx;
      if (w_tick && r_s == S_MID) r_smp[1] <= w_rx;
      if (r_state == S_DATA && w_dec) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (w_start) r_par_mis <= 1'b0;
      else if (r_state == S_PARITY && w_dec) r_par_mis <= w_maj ^ w_exp_par;
      r_done <= (r_state == S_STOP) && w_dec;
      if ((r_state == S_STOP) && w_dec) begin
        r_ferr_new <= !w_maj;
`ifdef UART_RX_BREAK_DETECT_EN
        r_brk_new  <= w_brk_frame;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_brk   <= 1'b0;
`endif
    end else if (w_load) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
      r_ferr  <= r_ferr_new;
      r_perr  <= r_par_mis;
      if (w_hs) r_ovr <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_brk   <= r_brk_new;
`endif
    end else if (r_done) begin
      r_ovr   <= 1'b1;
    end else if (w_hs) begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_brk   <= 1'b0;
`endif
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det  = r_brk;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: default 8N1 instance plus a fast even-parity instance driven with random frames.
module tb_uart_rx_os;
  localparam int CF0 = 12000000, BR0 = 19200, OS0 = 16;
  localparam int BP0 = (CF0 / (BR0 * OS0)) * OS0;
  localparam int CF1 = 1000000, BR1 = 31250, OS1 = 8;
  localparam int BP1 = (CF1 / (BR1 * OS1)) * OS1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic en0 = 1'b1, en1 = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0;
  logic [7:0] d0, d1;
  logic v0, fe0, pe0, ov0, busy0;
  logic v1, fe1, pe1, ov1, busy1;
`ifdef UART_RX_BREAK_DETECT_EN
  logic brk0, brk1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #5 clk = ~clk;

  uart_rx_os #(.CLOCK_FREQ(CF0), .BAUD_RATE(BR0), .DATA_BITS(8), .PARITY(0), .OVERSAMPLE(OS0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd0), .enable(en0), .data(d0), .valid(v0), .ready(rdy0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det(brk0),
`endif
    .busy(busy0));

  uart_rx_os #(.CLOCK_FREQ(CF1), .BAUD_RATE(BR1), .DATA_BITS(8), .PARITY(2), .OVERSAMPLE(OS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd1), .enable(en1), .data(d1), .valid(v1), .ready(rdy1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det(brk1),
`endif
    .busy(busy1));

  // Every accepted word (valid && ready at the sampling edge) is logged as {pe, fe, data}.
  always @(negedge clk) begin
    if (v0 && rdy0) q0.push_back({pe0, fe0, d0});
    if (v1 && rdy1) q1.push_back({pe1, fe1, d1});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return 1'(($countones(d) % 2) == 1);
  endfunction

  task automatic drive(input int ch, input logic b, input int n);
    if (ch == 0) rxd0 = b;
    else         rxd1 = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic sbit);
    int bp;
    bp = (ch == 0) ? BP0 : BP1;
    drive(ch, 1'b0, bp);
    for (int i = 0; i < 8; i++) drive(ch, d[i], bp);
    if (use_par) drive(ch, pbit, bp);
    drive(ch, sbit, bp);
  endtask

  task automatic pulse_ready1();
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
  endtask

  task automatic check_q1(input string tag, input logic [7:0] ed, input logic efe, input logic epe);
    logic [9:0] e;
    check_val({tag, "_cnt"}, 32'(q1.size()), 1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_val({tag, "_data"}, 32'(e[7:0]), 32'(ed));
      check_val({tag, "_fe"},   32'(e[8]),   32'(efe));
      check_val({tag, "_pe"},   32'(e[9]),   32'(epe));
    end
  endtask

  initial begin
    logic [9:0] e;
    logic [7:0] d, d2;
    logic good, pbit, sbit;
    int mode;

    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_valid", 32'(v0), 0);
    check_val("rst_data",  32'(d0), 0);
    check_val("rst_flags", 32'({fe0, pe0, ov0}), 0);
    check_val("rst_busy",  32'(busy0), 0);
    check_val("rst_valid1", 32'(v1), 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 0xA5 8N1, ready held high
    rdy0 = 1'b1;
    q0.delete();
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check_val("a5_cnt", 32'(q0.size()), 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_val("a5_data", 32'(e[7:0]), 'hA5);
      check_val("a5_fe",   32'(e[8]), 0);
      check_val("a5_pe",   32'(e[9]), 0);
    end
    check_val("a5_busy",  32'(busy0), 0);
    check_val("a5_valid", 32'(v0), 0);

    // false start: low for ~3 ticks
    drive(0, 1'b0, 117);
    check_val("fs_busy_hi", 32'(busy0), 1);
    drive(0, 1'b1, 2 * BP0);
    check_val("fs_busy_lo", 32'(busy0), 0);
    check_val("fs_none",    32'(q0.size()), 0);
    check_val("fs_valid",   32'(v0), 0);

    // stop bit low
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, BP0);
    check_val("fe_cnt", 32'(q0.size()), 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_val("fe_data", 32'(e[7:0]), 'h3C);
      check_val("fe_fe",   32'(e[8]), 1);
    end

    // overrun: two back-to-back frames with ready low
    rdy0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check_val("ov_first_valid", 32'(v0), 1);
    check_val("ov_first_ovr",   32'(ov0), 0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check_val("ov_valid", 32'(v0), 1);
    check_val("ov_data",  32'(d0), 'h11);
    check_val("ov_ovr",   32'(ov0), 1);
    check_val("ov_fe",    32'(fe0), 0);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    check_val("ov_clr_valid", 32'(v0), 0);
    check_val("ov_clr_ovr",   32'(ov0), 0);

    // reset in the middle of data bit 4 with a word pending
    send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
    check_val("pend_valid", 32'(v0), 1);
    check_val("pend_data",  32'(d0), 'h96);
    d = 8'hC3;
    drive(0, 1'b0, BP0);
    for (int i = 0; i < 4; i++) drive(0, d[i], BP0);
    drive(0, d[4], BP0 / 2);
    check_val("mid_busy", 32'(busy0), 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(v0), 0);
    check_val("arst_data",  32'(d0), 0);
    check_val("arst_flags", 32'({fe0, pe0, ov0}), 0);
    check_val("arst_busy",  32'(busy0), 0);
    rxd0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BP0) @(negedge clk);
    q0.delete();
    rdy0 = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check_val("post_cnt", 32'(q0.size()), 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_val("post_data", 32'(e[7:0]), 'h5A);
      check_val("post_fe",   32'(e[8]), 0);
    end

    // even parity: 0x07 needs parity bit 1
    rdy1 = 1'b0;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_val("par0_valid", 32'(v1), 1);
    check_val("par0_data",  32'(d1), 'h07);
    check_val("par0_pe",    32'(pe1), 1);
    check_val("par0_fe",    32'(fe1), 0);
    pulse_ready1();
    check_val("par0_clr", 32'({v1, pe1}), 0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check_val("par1_valid", 32'(v1), 1);
    check_val("par1_pe",    32'(pe1), 0);
    pulse_ready1();

    for (int it = 0; it < 30; it++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      pbit = even_par(d) ^ !good;
      sbit = ($urandom_range(0, 3) != 0);
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        q1.delete();
        rdy1 = 1'b1;
        send_frame(1, d, 1'b1, pbit, sbit);
        drive(1, 1'b1, BP1);
        check_q1("rnd_q", d, !sbit, !good);
        rdy1 = 1'b0;
      end else begin
        rdy1 = 1'b0;
        send_frame(1, d, 1'b1, pbit, sbit);
        if (mode == 2) begin
          if (!sbit) drive(1, 1'b1, BP1);
          d2 = 8'($urandom_range(0, 255));
          send_frame(1, d2, 1'b1, even_par(d2), 1'b1);
        end
        drive(1, 1'b1, BP1);
        check_val("rnd_valid", 32'(v1), 1);
        check_val("rnd_data",  32'(d1), 32'(d));
        check_val("rnd_fe",    32'(fe1), 32'(!sbit));
        check_val("rnd_pe",    32'(pe1), 32'(!good));
        check_val("rnd_ovr",   32'(ov1), 32'(mode == 2));
        pulse_ready1();
        check_val("rnd_clr", 32'({v1, fe1, pe1, ov1}), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
